// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: glitch-filtered clock, checked frames, E0/F0 prefix decode, code FIFO.
// Define PS2_ERR_CNT_EN to build the saturating error counter on err_cnt (tied to zero otherwise).
module ps2_rx_fifo #(
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 50000,
  parameter int FIFO_DEPTH  = 8,
  parameter int FIFO_AW     = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  output logic [9:0]       code_data,
  output logic             code_valid,
  input  logic             code_ready,
  output logic [FIFO_AW:0] fifo_count,
  output logic             frame_err,
  output logic             overflow,
  input  logic             clr_ovf,
  output logic [7:0]       err_cnt
);
  // state  | meaning
  // IDLE   | bus idle, waiting for a start bit (data low on a fall)
  // DATA   | shifting 8 data bits, LSB first
  // PARITY | capturing the parity bit
  // STOP   | checking stop bit and odd parity
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  localparam int              GW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [3:0]      FLT_TC   = 4'(FILTER_LEN - 1);
  localparam logic [GW-1:0]   GAP_LOAD = GW'(TIMEOUT_CYC - 1);
  localparam logic [GW-1:0]   GAP_ONE  = GW'(1);
  localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW + 1)'(FIFO_DEPTH);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

  logic       clk_s1, clk_s2, dat_s1, dat_s2;
  logic       clk_filt, clk_filt_d, fall;
  logic [3:0] flt_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1     <= 1'b1;
      clk_s2     <= 1'b1;
      dat_s1     <= 1'b1;
      dat_s2     <= 1'b1;
      clk_filt   <= 1'b1;
      clk_filt_d <= 1'b1;
      flt_cnt    <= '0;
    end else begin
      clk_s1     <= ps2_clk;
      clk_s2     <= clk_s1;
      dat_s1     <= ps2_data;
      dat_s2     <= dat_s1;
      clk_filt_d <= clk_filt;
      if (clk_s2 == clk_filt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FLT_TC) begin
        clk_filt <= clk_s2;
        flt_cnt  <= '0;
      end else begin
        flt_cnt <= flt_cnt + 4'd1;
      end
    end
  end

  assign fall = clk_filt_d & ~clk_filt;

  state_t        state, state_nx;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [GW-1:0] gap;
  logic          timeout, frame_ok, frame_bad;
  logic          byte_done, stop_err;

  always_comb begin
    state_nx  = state;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    // gap counts down from the last fall; reaching zero means the frame stalled
    timeout   = (state != S_IDLE) && !fall && (gap == '0);
    if (timeout) begin
      state_nx = S_IDLE;
    end else if (fall) begin
      case (state)
        S_IDLE:   if (!dat_s2) state_nx = S_DATA;
        S_DATA:   if (bit_cnt == 3'd7) state_nx = S_PARITY;
        S_PARITY: state_nx = S_STOP;
        S_STOP: begin
          state_nx = S_IDLE;
          if (dat_s2 && (^{shreg, par_bit})) frame_ok = 1'b1;
          else                               frame_bad = 1'b1;
        end
        default:  state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      gap       <= '0;
      byte_done <= 1'b0;
      stop_err  <= 1'b0;
    end else begin
      state     <= state_nx;
      byte_done <= frame_ok;
      stop_err  <= frame_bad;
      if (fall)                            gap <= GAP_LOAD;
      else if (state == S_IDLE || timeout) gap <= '0;
      else                                 gap <= gap - GAP_ONE;
      if (fall) begin
        case (state)
          S_IDLE: bit_cnt <= '0;
          S_DATA: begin
            shreg[bit_cnt] <= dat_s2;
            bit_cnt        <= bit_cnt + 3'd1;
          end
          S_PARITY: par_bit <= dat_s2;
          default: ;
        endcase
      end
    end
  end

  assign frame_err = stop_err | timeout;

  logic expand, brk, push, pop, full, do_push, drop;

  assign push = byte_done && (shreg != 8'hE0) && (shreg != 8'hF0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expand <= 1'b0;
      brk    <= 1'b0;
    end else if (frame_err) begin
      expand <= 1'b0;
      brk    <= 1'b0;
    end else if (byte_done) begin
      if (shreg == 8'hE0)      expand <= 1'b1;
      else if (shreg == 8'hF0) brk    <= 1'b1;
      else begin
        expand <= 1'b0;
        brk    <= 1'b0;
      end
    end
  end

  logic [9:0]         mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;

  assign code_valid = (fifo_count != '0);
  assign full       = (fifo_count == CNT_FULL);
  assign pop        = code_valid & code_ready;
  // a pop frees the slot being written, so push-while-full-with-pop is legal
  assign do_push    = push & (~full | pop);
  assign drop       = push & full & ~pop;
  assign code_data  = code_valid ? mem[rd_ptr] : 10'd0;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {expand, brk, shreg};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_ONE;
        2'b01:   fifo_count <= fifo_count - CNT_ONE;
        default: ;
      endcase
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

`ifdef PS2_ERR_CNT_EN
  logic [7:0] err_q;
  logic [8:0] err_sum;

  assign err_sum = {1'b0, err_q} + {8'd0, frame_err} + {8'd0, drop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= '0;
    else        err_q <= err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  assign err_cnt = err_q;
`else
  assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: directed frame table, timeout/latency/overflow/reset sequences,
// and randomized frames checked against a frame-level prefix/FIFO model.
module tb_ps2_rx_fifo;
  localparam int FL = 4, TO = 300, DEPTH = 8, AW = 3, H = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ps2_clk = 1'b1;
  logic          ps2_data = 1'b1;
  logic          code_ready = 1'b0;
  logic          clr_ovf = 1'b0;
  logic [9:0]    code_data;
  logic          code_valid;
  logic [AW:0]   fifo_count;
  logic          frame_err, overflow;
  logic [7:0]    err_cnt;

  int checks = 0, errors = 0;
  int ready_mode = 0;
  int err_seen = 0, valid_cyc = 0;
  int exp_err_tot = 0, drop_tot = 0;
  logic [9:0] got_q[$];
  logic [9:0] exp_q[$];
  logic m_exp = 1'b0, m_brk = 1'b0;

  always #5 clk = ~clk;

  ps2_rx_fifo #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO), .FIFO_DEPTH(DEPTH), .FIFO_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .code_data(code_data), .code_valid(code_valid), .code_ready(code_ready),
    .fifo_count(fifo_count), .frame_err(frame_err), .overflow(overflow),
    .clr_ovf(clr_ovf), .err_cnt(err_cnt)
  );

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       code_ready = 1'b0;
      1:       code_ready = 1'b1;
      default: code_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_err) err_seen++;
      if (code_valid) valid_cyc++;
      if (code_valid && code_ready) got_q.push_back(code_data);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int exp_ec();
    int s;
    s = exp_err_tot + drop_tot;
`ifdef PS2_ERR_CNT_EN
    return (s > 255) ? 255 : s;
`else
    return 0 * s;
`endif
  endfunction

  // sends the first nbits of a frame; optional 2-cycle low glitch in the high phase before bit glitch_bit
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nbits, input int glitch_bit);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      if (i == glitch_bit) begin
        tick(H / 2);
        ps2_clk = 1'b0;
        tick(2);
        ps2_clk = 1'b1;
        tick(H - H / 2 - 2);
      end else begin
        tick(H);
      end
      ps2_clk = 1'b0;
      tick(H);
      ps2_clk = 1'b1;
    end
    if (nbits == 11) begin
      ps2_data = 1'b1;
      tick(H);
    end
  endtask

  // frame-level reference: prefixes accumulate, any other byte emits a code, errors clear prefixes
  task automatic model_frame(input logic [7:0] b, input bit bad);
    if (bad) begin
      exp_err_tot++;
      m_exp = 1'b0;
      m_brk = 1'b0;
    end else if (b == 8'hE0) begin
      m_exp = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      exp_q.push_back({m_exp, m_brk, b});
      m_exp = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  typedef struct {
    logic [7:0] data;
    bit         bad_par;
    bit         bad_stop;
    int         glitch;
    int         n_push;
    logic [9:0] code;
    int         n_err;
  } vec_t;

  initial begin
    vec_t vt[14];
    int e0, v0, first, nerr, r;
    logic [7:0] b;
    bit bp, bs;

    vt[0]  = '{8'h1C, 1'b0, 1'b0, -1, 1, 10'h01C, 0};
    vt[1]  = '{8'hE0, 1'b0, 1'b0, -1, 0, 10'h000, 0};
    vt[2]  = '{8'hF0, 1'b0, 1'b0, -1, 0, 10'h000, 0};
    vt[3]  = '{8'h75, 1'b0, 1'b0, -1, 1, 10'h375, 0};
    vt[4]  = '{8'h75, 1'b0, 1'b0, -1, 1, 10'h075, 0};
    vt[5]  = '{8'h1C, 1'b1, 1'b0, -1, 0, 10'h000, 1};
    vt[6]  = '{8'h1C, 1'b0, 1'b0, -1, 1, 10'h01C, 0};
    vt[7]  = '{8'hE0, 1'b0, 1'b0, -1, 0, 10'h000, 0};
    vt[8]  = '{8'h1C, 1'b0, 1'b1, -1, 0, 10'h000, 1};
    vt[9]  = '{8'h29, 1'b0, 1'b0, -1, 1, 10'h029, 0};
    vt[10] = '{8'hF0, 1'b0, 1'b0, -1, 0, 10'h000, 0};
    vt[11] = '{8'h6B, 1'b0, 1'b0,  4, 1, 10'h16B, 0};
    vt[12] = '{8'hE0, 1'b0, 1'b0,  0, 0, 10'h000, 0};
    vt[13] = '{8'h5A, 1'b0, 1'b0,  9, 1, 10'h25A, 0};

    // reset state
    tick(3);
    chk("rst_code_data", 32'(code_data), 32'h0);
    chk("rst_code_valid", 32'(code_valid), 32'h0);
    chk("rst_fifo_count", 32'(fifo_count), 32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    chk("rst_err_cnt", 32'(err_cnt), 32'h0);
    rst_n = 1'b1;
    tick(5);

    // directed frame table, consumer always ready
    ready_mode = 1;
    tick(2);
    for (int i = 0; i < 14; i++) begin
      got_q.delete();
      e0 = err_seen;
      v0 = valid_cyc;
      send_frame(vt[i].data, vt[i].bad_par, vt[i].bad_stop, 11, vt[i].glitch);
      tick(10);
      exp_err_tot += vt[i].n_err;
      chk($sformatf("vec%0d_pushes", i), 32'(got_q.size()), 32'(vt[i].n_push));
      if (vt[i].n_push > 0 && got_q.size() > 0)
        chk($sformatf("vec%0d_code", i), 32'(got_q[0]), 32'(vt[i].code));
      chk($sformatf("vec%0d_frame_err", i), 32'(err_seen - e0), 32'(vt[i].n_err));
      chk($sformatf("vec%0d_valid_cycles", i), 32'(valid_cyc - v0), 32'(vt[i].n_push));
      chk($sformatf("vec%0d_fifo_count", i), 32'(fifo_count), 32'h0);
    end
    chk("err_cnt_after_table", 32'(err_cnt), 32'(exp_ec()));

    // stuck frame: start + 5 data bits then clock stays high
    got_q.delete();
    e0 = err_seen;
    send_frame(8'hA5, 1'b0, 1'b0, 5, -1);
    ps2_data = 1'b0;
    tick(H);
    ps2_clk = 1'b0;
    first = -1;
    nerr = 0;
    for (int i = 1; i <= FL + 2 + TO + 5; i++) begin
      tick(1);
      if (i == H) ps2_clk = 1'b1;
      if (frame_err) begin
        nerr++;
        if (first < 0) first = i;
      end
    end
    exp_err_tot++;
    chk("timeout_latency", 32'(first), 32'(FL + 2 + TO));
    chk("timeout_pulse_width", 32'(nerr), 32'd1);
    ps2_data = 1'b1;
    tick(5);
    send_frame(8'h29, 1'b0, 1'b0, 11, -1);
    tick(10);
    chk("after_timeout_pushes", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) chk("after_timeout_code", 32'(got_q[0]), 32'h029);
    chk("after_timeout_errs", 32'(err_seen - e0), 32'd1);
    chk("err_cnt_after_timeout", 32'(err_cnt), 32'(exp_ec()));

    // stop-bit fall to code_valid latency, then fill and overflow with consumer stalled
    ready_mode = 0;
    tick(2);
    got_q.delete();
    send_frame(8'h01, 1'b0, 1'b0, 10, -1);
    ps2_data = 1'b1;
    tick(H);
    ps2_clk = 1'b0;
    first = -1;
    for (int i = 1; i <= FL + 8; i++) begin
      tick(1);
      if (code_valid && first < 0) first = i;
    end
    chk("push_latency", 32'(first), 32'(FL + 4));
    tick(H);
    ps2_clk = 1'b1;
    tick(H);
    for (int k = 2; k <= 8; k++) begin
      send_frame(8'(k), 1'b0, 1'b0, 11, -1);
      tick(5);
    end
    chk("full_count", 32'(fifo_count), 32'd8);
    chk("full_no_overflow", 32'(overflow), 32'd0);
    chk("full_head", 32'(code_data), 32'h001);
    send_frame(8'h09, 1'b0, 1'b0, 11, -1);
    tick(5);
    drop_tot++;
    chk("ovf_count", 32'(fifo_count), 32'd8);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("err_cnt_after_drop", 32'(err_cnt), 32'(exp_ec()));
    clr_ovf = 1'b1;
    tick(1);
    clr_ovf = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);
    ready_mode = 1;
    tick(20);
    chk("drain_size", 32'(got_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < got_q.size(); i++)
      chk($sformatf("drain%0d", i), 32'(got_q[i]), 32'(i + 1));
    chk("drain_count", 32'(fifo_count), 32'd0);

    // reset mid-frame flushes the FIFO and aborts the frame
    ready_mode = 0;
    tick(2);
    send_frame(8'h33, 1'b0, 1'b0, 11, -1);
    tick(5);
    chk("prereset_count", 32'(fifo_count), 32'd1);
    send_frame(8'h44, 1'b0, 1'b0, 5, -1);
    rst_n = 1'b0;
    #1;
    chk("midrst_count", 32'(fifo_count), 32'd0);
    chk("midrst_valid", 32'(code_valid), 32'd0);
    chk("midrst_err_cnt", 32'(err_cnt), 32'd0);
    tick(3);
    rst_n = 1'b1;
    exp_err_tot = 0;
    drop_tot = 0;
    tick(3);
    ready_mode = 1;
    tick(2);
    got_q.delete();
    e0 = err_seen;
    send_frame(8'h4D, 1'b0, 1'b0, 11, -1);
    tick(10);
    chk("postrst_pushes", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) chk("postrst_code", 32'(got_q[0]), 32'h04D);
    chk("postrst_errs", 32'(err_seen - e0), 32'd0);

    // randomized frames with a randomly stalling consumer
    ready_mode = 2;
    got_q.delete();
    exp_q.delete();
    m_exp = 1'b0;
    m_brk = 1'b0;
    e0 = err_seen;
    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 7));
      b = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : 8'($urandom);
      bp = ($urandom_range(0, 9) == 0);
      bs = !bp && ($urandom_range(0, 9) == 0);
      send_frame(b, bp, bs, 11, -1);
      tick(int'($urandom_range(0, 30)));
      model_frame(b, bp || bs);
    end
    ready_mode = 1;
    tick(30);
    chk("rand_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("rand_code%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
    chk("rand_errs", 32'(err_seen - e0), 32'(exp_err_tot));
    chk("rand_err_cnt", 32'(err_cnt), 32'(exp_ec()));
    chk("rand_fifo_empty", 32'(fifo_count), 32'd0);
    chk("rand_no_overflow", 32'(overflow), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
- Parametrised PS/2 keyboard receiver; next generation of the game's keyboard front end.
- Improvements over the current receiver:
  - glitch-filtered PS/2 clock
  - full frame checking (start, odd parity, stop)
  - stuck-frame timeout
  - E0/F0 prefix decoding
  - FIFO of decoded codes with valid/ready handshake, so game logic never misses a key event
- Sits between the PS/2 pins and the game control FSM.

Parameters:
- FILTER_LEN, 4: cycles ps2_clk must hold a new level before the filtered level changes (range 1..15).
- TIMEOUT_CYC, 50000: max clk cycles between PS/2 falling edges inside a frame (1 ms at 50 MHz).
- FIFO_DEPTH, 8: code FIFO entries; power of two, ≥2.
- FIFO_AW, 3: log2(FIFO_DEPTH).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ps2_clk  in  1  raw PS/2 clock pin.
- ps2_data  in  1  raw PS/2 data pin.
- code_data  out  10  FIFO head, {expand, break, scancode[7:0]}.
- code_valid  out  1  FIFO not empty.
- code_ready  in  1  consumer pops head when code_valid & code_ready.
- fifo_count  out  FIFO_AW+1  current occupancy.
- frame_err  out  1  one-cycle pulse per rejected frame.
- overflow  out  1  sticky: a code was dropped because the FIFO was full.
- clr_ovf  in  1  synchronous clear of overflow.
- err_cnt  out  8  error counter (see Optional Feature).

Behaviour:
- Reset (rst_n low, async):
  - FSM in IDLE; all counters, flags and FIFO pointers zero.
  - code_data=0, code_valid=0, fifo_count=0, frame_err=0, overflow=0, err_cnt=0.
  - Synchroniser and filter reset to 1 (bus idle high).
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-flop synchroniser.
  - Filtered clock level updates only after FILTER_LEN consecutive equal synchronised samples.
  - fall = filtered 1→0, exactly one clk cycle wide.
  - ps2_data (synchronised) is sampled in the fall cycle.
- Frame FSM (advances only on fall, except timeout):
  - IDLE: data=0 → DATA, bit_cnt=0. data=1 → stay IDLE, no error.
  - DATA: shift the sample into byte[bit_cnt] (LSB first); at bit_cnt=7 → PARITY.
  - PARITY: store sample; → STOP.
  - STOP: sample=1 and odd parity over the 8 data bits plus parity bit → byte_done pulse next cycle. Otherwise frame_err. Either case → IDLE.
- Timeout:
  - Gap counter clears on every fall and counts while the FSM is not IDLE.
  - Reaching TIMEOUT_CYC-1 → IDLE, frame_err pulse, partial byte discarded.
  - The gap counter does not run in IDLE.
- Prefix decoder (on byte_done):
  - E0 → expand=1.
  - F0 → break=1.
  - Any other byte → push {expand, break, byte}, then clear expand and break.
  - frame_err also clears expand and break.
- Latency: stop-bit fall in cycle N → FIFO write in cycle N+1 → code_valid visible in N+2 when the FIFO was empty.
- FIFO:
  - Synchronous, first-word fall-through; code_data is the head register.
  - Pop and push in the same cycle are both performed; count is unchanged.
  - Push while full with no pop: code dropped, overflow←1. clr_ovf clears overflow; a simultaneous set wins.
  - Pop while empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset mid-frame aborts the frame and flushes the FIFO.

Optional Feature:
- Macro: PS2_ERR_CNT_EN.
- Defined:
  - err_cnt is an 8-bit counter incremented on each frame_err and on each dropped push.
  - Saturates at 255; cleared only by reset.
  - A frame_err and a drop in the same cycle add 2, saturating.
- Not defined: err_cnt tied to 0; no counter logic.

Test Plan:
- Valid frame 0x1C, code_ready=1 → code_data=0x01C, code_valid high for exactly one cycle, fifo_count returns to 0.
- Frames E0, F0, 75 → single entry 0x375. Next frame 75 → 0x075 (prefixes cleared).
- Frame 0x1C with wrong parity → frame_err pulse, no push, err_cnt=1 (macro on). Following valid 0x1C → 0x01C.
- Start bit plus 5 data bits, then clock held high → frame_err exactly TIMEOUT_CYC cycles after the last fall, FSM in IDLE. Next valid frame 0x29 → 0x029.
- FIFO_DEPTH=8, code_ready=0, frames 0x01..0x09 → fifo_count=8, overflow=1. Draining yields 0x001..0x008 in order. clr_ovf → overflow=0.
- FILTER_LEN=4, 2-cycle low glitch on ps2_clk in IDLE and mid-frame → no fall, no bit shifted; the frame still decodes correctly.
